pulse_decoder: RTL

PULSE_DECODER -- requirements
Module: pulse_decoder

---
 rtl/pulse_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pulse_decoder.sv
// ---------------------------------------------------------------------------
// pulse_decoder
//
// Watches the two lines coming out of a pulse generator and summarises each
// burst. A burst is the span in which the level line L is high; every rising
// edge of P seen while L is high counts as one pulse. When L drops, the
// decoder strobes done and presents the pulse count, whether the burst held
// several pulses, and (optionally) the spacing of the last two pulses.
//
// Optional feature macro:
//   PULSE_DECODER_PERIOD_EN  - when defined, builds an interval counter and
//                              reports the spacing of the last two pulses on
//                              period; when undefined, period is tied to 0.
//
// Parameters:
//   CNT_W   width of count and period (legal 2..16)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   P       in   pulse line (one-cycle-high pulses)
//   L       in   burst-level line (high for the whole burst)
//   active  out  high while the registered state is BURST
//   done    out  one-cycle strobe, burst finished; count/multi/period valid
//   count   out  pulses in the last completed burst (saturating)
//   multi   out  last completed burst held two or more pulses
//   period  out  cycles between the last two pulses of the last burst
//   err     out  one-cycle strobe: P high with L low, or P high twice in a row
// ---------------------------------------------------------------------------
module pulse_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             P,
    input  logic             L,
    output logic             active,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             multi,
    output logic [CNT_W-1:0] period,
    output logic             err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_t           state;
    state_t           state_d;
    logic             burst_start;
    logic             burst_end;
    logic             pulse;
    logic             err_d;
    logic             p_prev;
    logic [CNT_W-1:0] pulse_cnt;

    // State register. Reset wins over everything, including a burst in
    // progress, so an aborted burst never produces a done strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic plus the single-cycle events derived from the sampled
    // inputs. The state simply follows L, so back-to-back bursts separated by
    // one low sample still produce an IDLE visit and therefore their own done.
    always_comb begin
        state_d     = state;
        burst_start = 1'b0;
        burst_end   = 1'b0;
        case (state)
            IDLE: begin
                if (L) begin
                    state_d     = BURST;
                    burst_start = 1'b1;
                end
            end
            BURST: begin
                if (!L) begin
                    state_d   = IDLE;
                    burst_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A pulse is a rising edge of P qualified by L; it can land on the
        // very edge that opens the burst.
        pulse = P && !p_prev && L;
        // A high P is illegal outside a burst, and P must never be high on
        // two consecutive samples. Neither case ever forms a pulse, so an
        // error cannot disturb the count.
        err_d = P && (!L || p_prev);
    end

    assign active = (state == BURST);

    // Pulse history and the running pulse count. The count is cleared on
    // the edge that opens a burst, then a pulse on that same edge is added.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_prev    <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            p_prev <= P;
            if (burst_start) begin
                pulse_cnt <= pulse ? CNT_ONE : '0;
            end else if (pulse && (pulse_cnt != CNT_MAX)) begin
                pulse_cnt <= pulse_cnt + CNT_ONE;
            end
        end
    end

    // Result registers and strobes. count/multi hold between done strobes;
    // done and err are pure one-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            done  <= 1'b0;
            err   <= 1'b0;
            count <= '0;
            multi <= 1'b0;
        end else begin
            done <= burst_end;
            err  <= err_d;
            if (burst_end) begin
                count <= pulse_cnt;
                multi <= (pulse_cnt >= CNT_TWO);
            end
        end
    end

`ifdef PULSE_DECODER_PERIOD_EN
    logic [CNT_W-1:0] ivl_cnt;
    logic [CNT_W-1:0] last_ivl;

    // Interval measurement. ivl_cnt counts edges since the most recent
    // pulse (restarting at 1 on each pulse, saturating). At every pulse the
    // elapsed interval is captured into last_ivl, so at the end of the burst
    // last_ivl holds the spacing of the final two pulses. The value captured
    // on the first pulse of a burst is meaningless but is always overwritten
    // by a second pulse, and period is forced to 0 when fewer than two
    // pulses were seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            ivl_cnt  <= '0;
            last_ivl <= '0;
            period   <= '0;
        end else begin
            if (burst_start) begin
                ivl_cnt  <= pulse ? CNT_ONE : '0;
                last_ivl <= '0;
            end else if (state == BURST) begin
                if (pulse) begin
                    last_ivl <= ivl_cnt;
                    ivl_cnt  <= CNT_ONE;
                end else if (ivl_cnt != CNT_MAX) begin
                    ivl_cnt <= ivl_cnt + CNT_ONE;
                end
            end
            if (burst_end) begin
                period <= (pulse_cnt >= CNT_TWO) ? last_ivl : '0;
            end
        end
    end
`else
    assign period = '0;
`endif

endmodule
